sp_mem_arbiter: RTL and testbench

Serializes the per-lane memory requests of the N scalar-processor lanes in an SM core onto a single shared memory port. Sits between the lane array (per-lane `addr`/`data`/`q` buses) and the SM data memory. Driven by the SM controller's `MRead`/`MWrite` strobes, it services every enabled lane in ascending lane order, then returns `MReady`.

---
 rtl/sp_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_sp_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter: serializes the enabled lanes' memory requests of an SM core
// onto one shared memory port, in ascending lane order, then pulses MReady.
module sp_mem_arbiter #(
   parameter int N_CORES = 8,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MRead,
   input  logic                  MWrite,
   input  logic [N_CORES-1:0]    en,
   input  logic [N_CORES*AW-1:0] addr,
   input  logic [N_CORES*DW-1:0] data,
   output logic [N_CORES*DW-1:0] q,
   output logic                  MReady,
   output logic                  busy,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_wdata,
   input  logic                  mem_ack,
   input  logic [DW-1:0]         mem_rdata
);

   localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [N_CORES-1:0]   pend_q, pend_d;
   logic [IW-1:0]        cur_q, cur_d;
   logic                 op_we_q, op_we_d;
   logic [AW-1:0]        addr_q [N_CORES];
   logic [AW-1:0]        addr_d [N_CORES];
   logic [DW-1:0]        data_q [N_CORES];
   logic [DW-1:0]        data_d [N_CORES];
   logic [DW-1:0]        q_q    [N_CORES];
   logic [DW-1:0]        q_d    [N_CORES];
   logic                 mem_we_q, mem_we_d;
   logic [AW-1:0]        mem_addr_q, mem_addr_d;
   logic [DW-1:0]        mem_wdata_q, mem_wdata_d;

   logic [AW-1:0]        addr_in [N_CORES];
   logic [DW-1:0]        data_in [N_CORES];
   logic [N_CORES-1:0]   pend_nxt;
   logic [IW-1:0]        first_in;
   logic [IW-1:0]        next_lane;

   // Unflatten lane inputs and flatten registered results.
   for (genvar g = 0; g < N_CORES; g++) begin : g_lane
      assign addr_in[g]         = addr[g*AW +: AW];
      assign data_in[g]         = data[g*DW +: DW];
      assign q[g*DW +: DW]      = q_q[g];
   end

   // Priority encoder: index of the lowest set bit (0 when none set).
   function automatic logic [IW-1:0] lowest(input logic [N_CORES-1:0] m);
      logic [IW-1:0] r;
      logic          found;
      r     = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_CORES; i++) begin
         if (m[i] && !found) begin
            r     = IW'(i);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Lane selection helpers: first lane of a new mask, next lane after an ack.
   always_comb begin
      first_in  = lowest(en);
      pend_nxt  = pend_q & ~(N_CORES'(1) << cur_q);
      next_lane = lowest(pend_nxt);
   end

   // Next-state logic: latch request on start, walk the pending mask on acks.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      cur_d       = cur_q;
      op_we_d     = op_we_q;
      addr_d      = addr_q;
      data_d      = data_q;
      q_d         = q_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         IDLE: begin
            if (MRead || MWrite) begin
               // A simultaneous MRead wins: the operation is a read.
               op_we_d = ~MRead;
               pend_d  = en;
               for (int unsigned i = 0; i < N_CORES; i++) begin
                  addr_d[i] = addr_in[i];
                  data_d[i] = data_in[i];
               end
               if (|en) begin
                  state_d     = ISSUE;
                  cur_d       = first_in;
                  mem_we_d    = ~MRead;
                  mem_addr_d  = addr_in[first_in];
                  mem_wdata_d = data_in[first_in];
               end else begin
                  state_d = DONE;
               end
            end
         end
         ISSUE: begin
            if (mem_ack) begin
               if (!op_we_q) begin
                  q_d[cur_q] = mem_rdata;
               end
               pend_d = pend_nxt;
               if (|pend_nxt) begin
                  cur_d       = next_lane;
                  mem_addr_d  = addr_q[next_lane];
                  mem_wdata_d = data_q[next_lane];
               end else begin
                  state_d     = DONE;
                  cur_d       = '0;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = '0;
                  mem_wdata_d = '0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         cur_q       <= '0;
         op_we_q     <= 1'b0;
         addr_q      <= '{default: '0};
         data_q      <= '{default: '0};
         q_q         <= '{default: '0};
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         cur_q       <= cur_d;
         op_we_q     <= op_we_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         q_q         <= q_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Status and request outputs decoded from the registered state.
   always_comb begin
      mem_req   = (state_q == ISSUE);
      MReady    = (state_q == DONE);
      busy      = (state_q != IDLE);
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
   end

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// tb_sp_mem_arbiter: directed, cycle-exact checks of sp_mem_arbiter against
// hand-computed expectations, using a simple memory model with programmable wait.
module tb_sp_mem_arbiter;

   localparam int N  = 8;
   localparam int AW = 16;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            MRead, MWrite;
   logic [N-1:0]    en;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] data;
   logic [N*DW-1:0] q;
   logic            MReady, busy, mem_req, mem_we, mem_ack;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata, mem_rdata;

   int              n_err = 0;
   int              n_chk = 0;
   int              rdy_cnt = 0;
   int              wait_n = 0;
   int              wcnt = 0;
   logic [DW-1:0]   key = '0;

   sp_mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .MRead     (MRead),
      .MWrite    (MWrite),
      .en        (en),
      .addr      (addr),
      .data      (data),
      .q         (q),
      .MReady    (MReady),
      .busy      (busy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: ack after wait_n stall cycles, data = (A000 + addr) ^ key.
   assign mem_ack   = mem_req && (wcnt == wait_n);
   assign mem_rdata = (16'hA000 + mem_addr) ^ key;

   always @(posedge clk) begin
      if (reset || !mem_req || mem_ack) wcnt <= 0;
      else                              wcnt <= wcnt + 1;
   end

   always @(negedge clk) begin
      if (MReady) rdy_cnt = rdy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk = n_chk + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] lane_q(input int i);
      return DW'(q >> (DW * i));
   endfunction

   task automatic set_addr(input logic [AW-1:0] base);
      for (int i = 0; i < N; i++) addr[i*AW +: AW] = base + AW'(i);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_rdy"},  MReady,  1'b0);
      chk({tag, "_busy"}, busy,    1'b0);
      chk({tag, "_req"},  mem_req, 1'b0);
   endtask

   initial begin
      int k;
      int ln;
      reset  = 1'b1;
      MRead  = 1'b0;
      MWrite = 1'b0;
      en     = '0;
      addr   = '0;
      data   = '0;
      tick; tick;

      // Reset state
      chk("rst_rdy",   MReady,    1'b0);
      chk("rst_busy",  busy,      1'b0);
      chk("rst_req",   mem_req,   1'b0);
      chk("rst_we",    mem_we,    1'b0);
      chk("rst_addr",  mem_addr,  16'h0000);
      chk("rst_wdata", mem_wdata, 16'h0000);
      chk("rst_q",     q,         128'h0);
      reset = 1'b0;
      tick;

      // Full read: 8 lanes, zero wait
      wait_n = 0;
      en     = 8'hFF;
      set_addr(16'h0100);
      MRead  = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick;
         MRead = 1'b0;
         chk("fr_req",  mem_req,  1'b1);
         chk("fr_we",   mem_we,   1'b0);
         chk("fr_busy", busy,     1'b1);
         chk("fr_rdy",  MReady,   1'b0);
         chk("fr_addr", mem_addr, 16'h0100 + 16'(c - 1));
      end
      tick;
      chk("fr_rdy9",  MReady,  1'b1);
      chk("fr_req9",  mem_req, 1'b0);
      chk("fr_busy9", busy,    1'b1);
      tick;
      chk_idle("fr_end");
      for (int i = 0; i < N; i++) chk("fr_q", lane_q(i), 16'hA100 + 16'(i));

      // Sparse write, two wait cycles per request: lanes 2, 5, 7
      wait_n = 2;
      en     = 8'b1010_0100;
      for (int i = 0; i < N; i++) data[i*DW +: DW] = 16'(i) << 4;
      MWrite = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick;
         MWrite = 1'b0;
         ln = (c <= 3) ? 2 : (c <= 6) ? 5 : 7;
         chk("sw_req",   mem_req,   1'b1);
         chk("sw_we",    mem_we,    1'b1);
         chk("sw_rdy",   MReady,    1'b0);
         chk("sw_addr",  mem_addr,  16'h0100 + 16'(ln));
         chk("sw_wdata", mem_wdata, 16'(ln) << 4);
      end
      tick;
      chk("sw_rdy10", MReady,  1'b1);
      chk("sw_req10", mem_req, 1'b0);
      tick;
      chk_idle("sw_end");
      for (int i = 0; i < N; i++) chk("sw_q", lane_q(i), 16'hA100 + 16'(i));

      // Empty mask
      wait_n = 0;
      en     = '0;
      MRead  = 1'b1;
      tick;
      MRead = 1'b0;
      chk("em_rdy",  MReady,  1'b1);
      chk("em_req",  mem_req, 1'b0);
      chk("em_busy", busy,    1'b1);
      tick;
      chk_idle("em_end");

      // Both strobes, then a restart attempt while busy
      key    = 16'h0F00;
      en     = 8'b0000_0011;
      MRead  = 1'b1;
      MWrite = 1'b1;
      k      = rdy_cnt;
      tick;
      MWrite = 1'b0;
      chk("bs_we1",   mem_we,   1'b0);
      chk("bs_addr1", mem_addr, 16'h0100);
      chk("bs_req1",  mem_req,  1'b1);
      tick;
      MRead = 1'b0;
      chk("bs_we2",   mem_we,   1'b0);
      chk("bs_addr2", mem_addr, 16'h0101);
      tick;
      chk("bs_rdy3", MReady, 1'b1);
      tick;
      chk_idle("bs_end");
      tick;
      chk_idle("bs_end2");
      chk("bs_pulses", rdy_cnt - k, 1);
      chk("bs_q0", lane_q(0), 16'hAE00);
      chk("bs_q1", lane_q(1), 16'hAE01);
      chk("bs_q2", lane_q(2), 16'hA102);
      key = '0;

      // Reset during the third lane of a full read
      en    = 8'hFF;
      set_addr(16'h0200);
      MRead = 1'b1;
      k     = rdy_cnt;
      tick; MRead = 1'b0;
      tick;
      tick;
      chk("rm_addr3", mem_addr, 16'h0202);
      reset = 1'b1;
      tick;
      chk_idle("rm_after");
      chk("rm_q", q, 128'h0);
      reset = 1'b0;
      tick;
      chk_idle("rm_idle");
      chk("rm_pulses", rdy_cnt - k, 0);
      MRead = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick;
         MRead = 1'b0;
         chk("rm2_addr", mem_addr, 16'h0200 + 16'(c - 1));
      end
      tick;
      chk("rm2_rdy", MReady, 1'b1);
      tick;
      for (int i = 0; i < N; i++) chk("rm2_q", lane_q(i), 16'hA200 + 16'(i));

      // Inputs changed after the start edge
      en    = 8'b0001_0010;
      set_addr(16'h0300);
      MRead = 1'b1;
      tick;
      MRead = 1'b0;
      en    = 8'hFF;
      set_addr(16'h0400);
      chk("ic_addr1", mem_addr, 16'h0301);
      tick;
      chk("ic_addr2", mem_addr, 16'h0304);
      chk("ic_req2",  mem_req,  1'b1);
      tick;
      chk("ic_rdy", MReady,  1'b1);
      chk("ic_req", mem_req, 1'b0);
      tick;
      chk_idle("ic_end");
      for (int i = 0; i < N; i++) begin
         if (i == 1 || i == 4) chk("ic_q", lane_q(i), 16'hA300 + 16'(i));
         else                  chk("ic_q", lane_q(i), 16'hA200 + 16'(i));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
